// File: rtl/adau_i2s_receiver.sv
// I2S receiver for the ADAU ADC path: synchronizes bclk/lrclk/sdata into clk, captures
// left/right samples and buffers stereo frames in a show-ahead FIFO. Option: ADAU_I2S_RX_FRAME_ERR_EN.
module adau_i2s_receiver #(
  parameter int WIDTH       = 24,
  parameter int SLOT_BITS   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable_audio,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [2*WIDTH-1:0] audio_out,
  output logic               audio_out_valid,
  input  logic               audio_out_ready,
  output logic               overflow
`ifdef ADAU_I2S_RX_FRAME_ERR_EN
  ,
  output logic [15:0]        frame_err_cnt
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 31 || SLOT_BITS <= WIDTH || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_STAGES < 2) begin : g_param_check
    $error("adau_i2s_receiver: illegal parameter combination");
  end

  typedef enum logic [1:0] {WAIT_LEFT, CAP_LEFT, CAP_RIGHT} state_t;

  // Input synchronizers: all three pins share the same depth so they stay aligned.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic bclk_s, lrclk_s, sdata_s, bclk_d, bclk_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      bclk_d <= 1'b0;
    end else begin
      // NOTE: clocked state always uses <=, so every flop samples the pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], {bclk, lrclk, sdata}};
      bclk_d <= bclk_s;
    end
  end

  assign {bclk_s, lrclk_s, sdata_s} = sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d;

  // Slot tracking: the first lrclk change after reset only arms edge detection.
  logic             lrclk_prev, lr_armed;
  logic             lr_edge, slot_start, data_bit, cnt_hit;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift, shift_next, left_hold;
  state_t           state, state_d;
  logic             push_req;

  assign lr_edge    = bclk_rise & (lrclk_s != lrclk_prev);
  assign slot_start = lr_edge & lr_armed;
  assign data_bit   = bclk_rise & ~lr_edge & (cnt < CNT_FULL);
  assign cnt_hit    = data_bit & (cnt == CNT_LAST);
  assign shift_next = WIDTH'({shift, sdata_s});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrclk_prev <= 1'b0;
      lr_armed   <= 1'b0;
      cnt        <= '0;
      shift      <= '0;
      left_hold  <= '0;
    end else if (bclk_rise) begin
      if (lr_edge) begin
        lrclk_prev <= lrclk_s;
        lr_armed   <= 1'b1;
      end
      if (slot_start) begin
        cnt <= '0;
      end else if (data_bit) begin
        shift <= shift_next;
        cnt   <= cnt + CW'(1);
      end
      if (cnt_hit && state == CAP_LEFT) left_hold <= shift_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_LEFT;
    else          state <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d  = state;
    push_req = 1'b0;
    case (state)
      WAIT_LEFT: if (slot_start && !lrclk_s) state_d = CAP_LEFT;
      CAP_LEFT:  if (slot_start) state_d = (cnt == CNT_FULL && lrclk_s) ? CAP_RIGHT : WAIT_LEFT;
      CAP_RIGHT: begin
        push_req = cnt_hit;
        if (slot_start) state_d = lrclk_s ? WAIT_LEFT : CAP_LEFT;
      end
      default:   state_d = WAIT_LEFT;
    endcase
    if (!enable_audio) begin
      state_d  = WAIT_LEFT;
      push_req = 1'b0;
    end
  end

  // Show-ahead FIFO with a registered head.
  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_next;
  logic [AW:0]        count, count_after_pop;
  logic               pop, full, push_ok, drop;
  logic [2*WIDTH-1:0] push_data, head_d;

  assign push_data       = {left_hold, shift_next};
  assign audio_out_valid = (count != '0);
  assign pop             = audio_out_valid & audio_out_ready;
  assign full            = (count == (AW+1)'(FIFO_DEPTH));
  assign push_ok         = push_req & (~full | pop);
  assign drop            = push_req & full & ~pop;
  assign rd_next         = rd_ptr + AW'(pop);
  assign count_after_pop = count - (AW+1)'(pop);

  always_comb begin
    head_d = mem[rd_next];
    if (count_after_pop == '0) head_d = push_ok ? push_data : audio_out;
  end

  // NOTE: storage is not reset; count gates every read, so stale contents never reach audio_out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      audio_out <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_next;
      count     <= count_after_pop + (AW+1)'(push_ok);
      audio_out <= head_d;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef ADAU_I2S_RX_FRAME_ERR_EN
  // Slot length includes the delay bit; one increment per bad slot even if it is also short.
  localparam int LW = $clog2(SLOT_BITS + 1) + 1;
  logic [LW-1:0] slot_len;
  logic          slot_tracked, short_slot, len_err, err_inc;

  assign short_slot = slot_start & enable_audio & (state != WAIT_LEFT) & (cnt != CNT_FULL);
  assign len_err    = slot_start & slot_tracked & (slot_len != LW'(SLOT_BITS));
  assign err_inc    = short_slot | len_err | drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_len      <= '0;
      slot_tracked  <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      if (slot_start) begin
        slot_len     <= LW'(1);
        slot_tracked <= 1'b1;
      end else if (bclk_rise && slot_len != '1) begin
        slot_len <= slot_len + LW'(1);
      end
      if (err_inc && frame_err_cnt != 16'hFFFF) frame_err_cnt <= frame_err_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_adau_i2s_receiver.sv
// Self-checking bench for adau_i2s_receiver: table vectors, random frames against a
// frame-level reference model, and hand-written reset/enable/backpressure sequences.
module tb_adau_i2s_receiver;
  localparam int WIDTH = 24;
  localparam int SLOT  = 32;
  localparam int DEPTH = 4;
  localparam int HALF  = 5;

  logic clk = 1'b0, reset_n = 1'b0, enable_audio = 1'b0;
  logic bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0, audio_out_ready = 1'b0;
  logic [2*WIDTH-1:0] audio_out;
  logic audio_out_valid, overflow;
`ifdef ADAU_I2S_RX_FRAME_ERR_EN
  logic [15:0] frame_err_cnt;
`endif

  adau_i2s_receiver #(.WIDTH(WIDTH), .SLOT_BITS(SLOT), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable_audio(enable_audio),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .audio_out(audio_out), .audio_out_valid(audio_out_valid),
    .audio_out_ready(audio_out_ready), .overflow(overflow)
`ifdef ADAU_I2S_RX_FRAME_ERR_EN
    , .frame_err_cnt(frame_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int valid_cycles = 0;
  int prev_len = -1;
  int exp_frame_err = 0;
  bit exp_overflow = 1'b0;
  bit rand_ready = 1'b0;
  logic [2*WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
    int llen;
    int rlen;
    int beats;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n && audio_out_valid) valid_cycles++;
    if (reset_n && audio_out_valid && audio_out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h expected no beat", audio_out);
      end else begin
        check("beat", {16'h0, audio_out}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) audio_out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // One I2S slot: lrclk changes with bclk low, MSB follows one bclk after the change.
  task automatic drive_slot(input logic lr, input logic [WIDTH-1:0] data, input int nbits,
                            input bit tracked, input int en_bit = -1, input int rel_bit = -1);
    if (tracked && prev_len >= 0 && prev_len != SLOT) exp_frame_err++;
    for (int i = 0; i < nbits; i++) begin
      if (i == en_bit) enable_audio = 1'b1;
      if (i == rel_bit) reset_n = 1'b1;
      bclk  = 1'b0;
      lrclk = lr;
      sdata = (i >= 1 && i <= WIDTH) ? data[WIDTH-i] : 1'($urandom);
      tick(HALF);
      bclk = 1'b1;
      tick(HALF);
    end
    prev_len = tracked ? nbits : -1;
  endtask

  // Frame-level model: a complete frame lands in a 4-deep buffer or is dropped when it is full.
  task automatic send_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                            input int llen = SLOT, input int rlen = SLOT, input bit expect_push = 1'b1);
    if (expect_push) begin
      if (exp_q.size() >= DEPTH) begin
        exp_overflow = 1'b1;
        exp_frame_err++;
      end else begin
        exp_q.push_back({l, r});
      end
    end
    drive_slot(1'b0, l, llen, 1'b1);
    drive_slot(1'b1, r, rlen, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_err_cnt(input string name);
`ifdef ADAU_I2S_RX_FRAME_ERR_EN
    check(name, frame_err_cnt, exp_frame_err);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  initial begin
    int lens[8] = '{11, 24, 25, 28, 31, 32, 32, 33};
    vecs[0] = '{24'hABCDEF, 24'h123456, 32, 32, 1};
    vecs[1] = '{24'h111111, 24'h222222, 11, 32, 0};
    vecs[2] = '{24'h333333, 24'h444444, 32, 32, 1};
    vecs[3] = '{24'h555555, 24'h666666, 32, 10, 0};
    vecs[4] = '{24'h777777, 24'h888888, 25, 25, 1};
    vecs[5] = '{24'h999999, 24'hAAAAAA, 24, 32, 0};
    vecs[6] = '{24'hBBBBBB, 24'hCCCCCC, 32, 32, 1};

    tick(3);
    check("rst_valid", audio_out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_audio_out", {16'h0, audio_out}, 0);
    check_err_cnt("rst_frame_err");
    reset_n = 1'b1;
    enable_audio = 1'b1;
    audio_out_ready = 1'b1;
    tick(4);
    drive_slot(1'b1, '0, SLOT, 1'b0);

    for (int i = 0; i < 7; i++) begin
      valid_cycles = 0;
      send_frame(vecs[i].l, vecs[i].r, vecs[i].llen, vecs[i].rlen, vecs[i].beats != 0);
      tick(20);
      check($sformatf("vec%0d_beats", i), valid_cycles, vecs[i].beats);
    end
    check_err_cnt("table_frame_err");

    // Capture disabled for three frames, re-enabled mid-left slot.
    enable_audio = 1'b0;
    valid_cycles = 0;
    for (int i = 0; i < 3; i++) send_frame(24'(24'h0F0F00 + i), 24'(24'hF0F0F0 - i), SLOT, SLOT, 1'b0);
    check("en_off_no_push", valid_cycles, 0);
    drive_slot(1'b0, 24'h5A5A5A, SLOT, 1'b1, 12);
    drive_slot(1'b1, 24'hA5A5A5, SLOT, 1'b1);
    tick(20);
    check("en_resume_mid_left", valid_cycles, 0);
    send_frame(24'hC0FFEE, 24'hBEEF01);
    tick(20);
    check("en_resume_next_left", valid_cycles, 1);

    // Random frames with random slot lengths and random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int ll = lens[$urandom_range(0, 7)];
      int rl = lens[$urandom_range(0, 7)];
      send_frame(24'($urandom), 24'($urandom), ll, rl, (ll > WIDTH) && (rl > WIDTH));
    end
    rand_ready = 1'b0;
    audio_out_ready = 1'b1;
    wait_drain("rand_drain");
    check_err_cnt("rand_frame_err");

    // Backpressure: six frames into a four-deep buffer.
    audio_out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_frame(24'(i), 24'(i + 256));
    tick(20);
    check("bp_overflow", overflow, exp_overflow);
    check("bp_valid_held", audio_out_valid, 1);
    audio_out_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_overflow_sticky", overflow, 1);
    check_err_cnt("bp_frame_err");

    // Asynchronous reset with two frames buffered.
    audio_out_ready = 1'b0;
    send_frame(24'hFACE01, 24'hFACE02);
    send_frame(24'hFACE03, 24'hFACE04);
    tick(5);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_async_valid", audio_out_valid, 0);
    check("rst_async_overflow", overflow, 0);
    check_err_cnt("rst_async_frame_err_pre");
    exp_q.delete();
    exp_overflow = 1'b0;
    exp_frame_err = 0;
    prev_len = -1;
    audio_out_ready = 1'b1;
    check_err_cnt("rst_async_frame_err");

    // Reset released in the middle of a right slot: only later complete frames appear.
    valid_cycles = 0;
    drive_slot(1'b0, 24'hDEAD00, SLOT, 1'b0);
    drive_slot(1'b1, 24'hDEAD01, SLOT, 1'b0, -1, 12);
    tick(20);
    check("align_no_partial", valid_cycles, 0);
    send_frame(24'h13579B, 24'h2468AC);
    tick(20);
    check("align_first_frame", valid_cycles, 1);
    send_frame(24'($urandom), 24'($urandom));
    wait_drain("align_drain");
    check("final_overflow", overflow, exp_overflow);
    check_err_cnt("final_frame_err");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
